// File: rtl/and_or_arbiter_if.sv
// Request, response and and_or datapath signals shared between the arbiter
// (slave side) and its surrounding environment (master side).
interface and_or_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  // Requester 0
  logic             req0Valid;
  logic             req0Ready;
  logic [WIDTH-1:0] req0A;
  logic [WIDTH-1:0] req0B;
  logic             req0IsAnd;
  // Requester 1
  logic             req1Valid;
  logic             req1Ready;
  logic [WIDTH-1:0] req1A;
  logic [WIDTH-1:0] req1B;
  logic             req1IsAnd;
  // Shared and_or unit
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic             aluDoAnd;
  logic             aluDoOr;
  logic             aluIsAnd;
  logic [WIDTH-1:0] aluOut;
  // Response channel and status
  logic             resValid;
  logic             resReady;
  logic             resId;
  logic [WIDTH-1:0] resOut;
  logic             busy;
  logic             opError;

  modport slave (
    input  req0Valid, req0A, req0B, req0IsAnd,
    input  req1Valid, req1A, req1B, req1IsAnd,
    input  aluIsAnd, aluOut, resReady,
    output req0Ready, req1Ready,
    output aluA, aluB, aluDoAnd, aluDoOr,
    output resValid, resId, resOut, busy, opError
  );

  modport master (
    output req0Valid, req0A, req0B, req0IsAnd,
    output req1Valid, req1A, req1B, req1IsAnd,
    output aluIsAnd, aluOut, resReady,
    input  req0Ready, req1Ready,
    input  aluA, aluB, aluDoAnd, aluDoOr,
    input  resValid, resId, resOut, busy, opError
  );
endinterface

// File: rtl/and_or_arbiter.sv
// Round-robin arbiter sharing one combinational and_or unit between two
// requesters. Each accepted request is issued for one cycle, its result is
// registered and returned with the requester ID over a valid/ready channel.
module and_or_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  and_or_arbiter_if.slave  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             grant_id;
  logic             ready0;
  logic             ready1;
  logic             accept;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic             lat_is_and;
  logic             lat_id;
  logic             res_valid;
  logic             res_id;
  logic [WIDTH-1:0] res_out;
  logic             op_error;

  // Grant selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_id = (bus.req0Valid & bus.req1Valid) ? ~last_grant : bus.req1Valid;
    ready0   = ~rst & (state == StIdle) & bus.req0Valid & ~grant_id;
    ready1   = ~rst & (state == StIdle) & bus.req1Valid & grant_id;
    accept   = ready0 | ready1;
  end

  // FSM, operand latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_is_and <= 1'b0;
      lat_id     <= 1'b0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_out    <= '0;
      op_error   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            lat_a      <= grant_id ? bus.req1A : bus.req0A;
            lat_b      <= grant_id ? bus.req1B : bus.req0B;
            lat_is_and <= grant_id ? bus.req1IsAnd : bus.req0IsAnd;
            lat_id     <= grant_id;
            last_grant <= grant_id;
            state      <= StIssue;
          end
        end
        StIssue: begin
          res_out   <= bus.aluOut;
          res_id    <= lat_id;
          res_valid <= 1'b1;
          // The unit reports which op it performed; a disagreement is sticky.
          if (bus.aluIsAnd != lat_is_and) op_error <= 1'b1;
          state <= StResp;
        end
        StResp: begin
          if (bus.resReady) begin
            res_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Output decode; the datapath controls are only active during the issue cycle.
  always_comb begin
    bus.req0Ready = ready0;
    bus.req1Ready = ready1;
    bus.aluA      = lat_a;
    bus.aluB      = lat_b;
    bus.aluDoAnd  = (state == StIssue) & lat_is_and;
    bus.aluDoOr   = (state == StIssue) & ~lat_is_and;
    bus.resValid  = res_valid;
    bus.resId     = res_id;
    bus.resOut    = res_out;
    bus.busy      = (state != StIdle);
    bus.opError   = op_error;
  end

endmodule

// File: doc/and_or_arbiter.md
Name: and_or_arbiter

Overview:
- Shares one combinational and_or unit (4-bit AND/OR datapath) between two requesters.
- Each requester presents operands and an op select over a valid/ready handshake.
- The block grants requesters round-robin, sequences the and_or control inputs, registers the result, and returns it with the requester ID over a valid/ready response channel.
- Sits directly in front of the and_or instance.

Parameters:
- WIDTH, 4, operand/result width; must match the and_or unit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0Valid  in  1  requester 0 has a request.
- req0Ready  out  1  requester 0 request accepted this cycle.
- req0A  in  WIDTH  requester 0 operand A.
- req0B  in  WIDTH  requester 0 operand B.
- req0IsAnd  in  1  requester 0 op select: 1 = AND, 0 = OR.
- req1Valid, req1Ready, req1A, req1B, req1IsAnd: same as requester 0, for requester 1.
- aluA  out  WIDTH  to and_or aIn.
- aluB  out  WIDTH  to and_or bIn.
- aluDoAnd  out  1  to and_or doAnd.
- aluDoOr  out  1  to and_or doOr.
- aluIsAnd  in  1  from and_or isAnd.
- aluOut  in  WIDTH  from and_or out.
- resValid  out  1  response valid.
- resReady  in  1  response consumer ready.
- resId  out  1  requester ID of the response.
- resOut  out  WIDTH  result.
- busy  out  1  state != IDLE.
- opError  out  1  sticky flag: aluIsAnd disagreed with the issued op.

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Reset (rst high at a clock edge, any state, including mid-transaction):
  - state = IDLE; lastGrant = 1, so requester 0 wins the first tie.
  - resValid = 0, resId = 0, resOut = 0, opError = 0.
  - Latched operands and op are cleared to 0.
  - Any in-flight transaction is discarded; no response is produced for it.
  - While rst is high, req0Ready and req1Ready = 0.
- IDLE:
  - Grant selection: if exactly one reqNValid is high, grant it. If both are high, grant the requester that is not lastGrant.
  - reqNReady = 1 combinationally for the granted requester only; the other ready = 0.
  - On reqNValid & reqNReady: latch A, B, isAnd and ID; set lastGrant = N; go to ISSUE.
  - aluDoAnd = aluDoOr = 0 and aluA/aluB = latched values (don't-care) whenever not in ISSUE.
- ISSUE (exactly 1 cycle):
  - aluA/aluB = latched operands; aluDoAnd = latched isAnd; aluDoOr = ~latched isAnd. Exactly one of aluDoAnd/aluDoOr is high.
  - At the clock edge: resOut <= aluOut, resId <= latched ID, resValid <= 1.
  - If aluIsAnd != latched isAnd, opError <= 1.
  - Go to RESP.
- RESP:
  - resValid, resId and resOut are held stable until resValid & resReady.
  - On that handshake: resValid <= 0, go to IDLE.
  - No request is accepted in RESP: both readys = 0.
- Latency: request accepted at edge N; result captured at edge N+1; resValid high from N+1. Minimum issue interval is 3 cycles when resReady is tied high.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1.
- Requester input changes while ready = 0 are ignored; only values at the accept edge are used.
- opError is cleared only by rst.
- Op semantics: AND produces bitwise aIn & bIn; OR produces bitwise aIn | bIn.
- All outputs are driven from registers or state decode, except reqNReady, which also depends combinationally on reqNValid.

Test Plan:
- Reset then single request: rst for 2 cycles; req0 {A=4'b1100, B=4'b1010, isAnd=1} -> req0Ready=1 same cycle; aluDoAnd=1, aluDoOr=0 next cycle; resValid=1, resId=0, resOut=4'b1000 following cycle; opError=0.
- Simultaneous requests: both valid; req0 {0011, 0101, OR}, req1 {1111, 0110, AND}, resReady=1 -> first response resId=0, resOut=0111; second resId=1, resOut=0110; third tie grant goes to 0.
- Backpressure: resReady=0 for 5 cycles after resValid -> resValid, resId and resOut stable for those cycles; both readys = 0; accept only after the handshake.
- Reset mid-operation: rst asserted while in ISSUE with a pending req0 -> next cycle busy=0, resValid=0, no response emitted; the next request completes normally.
- Op mismatch: force aluIsAnd=0 while an AND op is issued -> opError=1 and stays 1 across later good ops until rst.
- Saturation fairness: both requesters valid for 12 cycles, resReady=1 -> exactly 4 grants alternating 0,1,0,1 with correct results per operands.
